// File: rtl/fpu_tb_pkg.sv
// Shared definitions for the FPU corner-case stimulus slice: op codes,
// operand constants, flag bit positions and the table entry record.
package fpu_tb_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011
  } fpu_op_e;

  localparam logic [31:0] INF     = 32'h7F80_0000;
  localparam logic [31:0] ZERO    = 32'h0000_0000;
  localparam logic [31:0] NUM_MAX = 32'h7F7F_FFFF;
  localparam logic [31:0] NUM_MIN = 32'h0000_0001;
  localparam logic [31:0] ONE     = 32'h3F80_0000;
  localparam logic [31:0] NEG_ONE = 32'hBF80_0000;
  localparam logic [31:0] TWO     = 32'h4000_0000;
  localparam logic [31:0] THREE   = 32'h4040_0000;
  localparam logic [31:0] PI      = 32'h4049_0FDB;
  localparam logic [31:0] HALF_UL = 32'h3380_0000;

  // Bit positions inside the FPU flag byte
  localparam int unsigned F_INF  = 7;
  localparam int unsigned F_SNAN = 6;
  localparam int unsigned F_QNAN = 5;
  localparam int unsigned F_INE  = 4;
  localparam int unsigned F_OVF  = 3;
  localparam int unsigned F_UNF  = 2;
  localparam int unsigned F_ZERO = 1;
  localparam int unsigned F_DBZ  = 0;

  typedef struct packed {
    fpu_op_e     op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [7:0]  exp;
    logic [7:0]  mask;
  } fpu_vec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_CHECK,
    S_GAP,
    S_DONE
  } drv_state_e;

  function automatic logic [7:0] flag_bit(input int unsigned pos);
    logic [7:0] f;
    f      = '0;
    f[pos] = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/fpu_vector_driver_if.sv
// FPU input/flag bundle between the vector driver (master) and the FPU (slave).
interface fpu_vector_driver_if;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [2:0]  fpu_op;
  logic [1:0]  rmode;
  logic [7:0]  flags;

  modport master (
    output opa, opb, fpu_op, rmode,
    input  flags
  );

  modport slave (
    input  opa, opb, fpu_op, rmode,
    output flags
  );
endinterface

// File: rtl/fpu_vector_rom.sv
// Fixed 16-entry corner-case table; mask equals the expected bits except
// entry 14, which demands a fully clean flag byte.
module fpu_vector_rom
  import fpu_tb_pkg::*;
(
  input  logic [3:0] idx_i,
  output fpu_vec_t   vec_o
);

  function automatic fpu_vec_t mk(input fpu_op_e op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [7:0] f);
    fpu_vec_t v;
    v.op   = op;
    v.opa  = a;
    v.opb  = b;
    v.exp  = f;
    v.mask = f;
    return v;
  endfunction

  always_comb begin
    vec_o = mk(OP_ADD, ONE, ONE, '0);
    unique case (idx_i)
      4'd0:  vec_o = mk(OP_ADD, ONE,     NEG_ONE, flag_bit(F_ZERO));
      4'd1:  vec_o = mk(OP_SUB, PI,      PI,      flag_bit(F_ZERO));
      4'd2:  vec_o = mk(OP_MUL, ZERO,    THREE,   flag_bit(F_ZERO));
      4'd3:  vec_o = mk(OP_DIV, ZERO,    THREE,   flag_bit(F_ZERO));
      4'd4:  vec_o = mk(OP_DIV, ONE,     ZERO,    flag_bit(F_DBZ));
      4'd5:  vec_o = mk(OP_ADD, INF,     ONE,     flag_bit(F_INF));
      4'd6:  vec_o = mk(OP_MUL, INF,     TWO,     flag_bit(F_INF));
      4'd7:  vec_o = mk(OP_MUL, ZERO,    INF,     flag_bit(F_QNAN));
      4'd8:  vec_o = mk(OP_SUB, INF,     INF,     flag_bit(F_QNAN));
      4'd9:  vec_o = mk(OP_DIV, INF,     INF,     flag_bit(F_QNAN));
      4'd10: vec_o = mk(OP_DIV, ZERO,    ZERO,    flag_bit(F_QNAN));
      4'd11: vec_o = mk(OP_MUL, NUM_MAX, TWO,     flag_bit(F_OVF));
      4'd12: vec_o = mk(OP_ADD, NUM_MAX, NUM_MAX, flag_bit(F_OVF));
      4'd13: vec_o = mk(OP_DIV, NUM_MIN, TWO,     flag_bit(F_UNF));
      4'd14: begin
        vec_o      = mk(OP_MUL, ONE, ONE, '0);
        vec_o.mask = 8'hFF;
      end
      4'd15: vec_o = mk(OP_ADD, ONE,     HALF_UL, flag_bit(F_INE));
      default: ;
    endcase
  end

endmodule

// File: rtl/fpu_vector_driver.sv
// Steps the corner-case table through the FPU, samples flags LATENCY cycles
// after each vector is first driven and tallies masked pass/fail results.
module fpu_vector_driver
  import fpu_tb_pkg::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned GAP     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  fpu_vector_driver_if.master        fpu,
  output logic                       busy,
  output logic                       done,
  output logic [4:0]                 pass_cnt,
  output logic [4:0]                 fail_cnt,
  output logic [15:0]                fail_map
);

  localparam logic [3:0] LAT_C = LATENCY[3:0];
  localparam logic [3:0] GAP_C = GAP[3:0];

  drv_state_e  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  sample_q, sample_d;
  logic [4:0]  pass_q, pass_d;
  logic [4:0]  fail_q, fail_d;
  logic [15:0] map_q, map_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [2:0]  op_q, op_d;

  fpu_vec_t vec;

  // Looked up on the next index: it feeds the registered operands and,
  // since the index is stable through CHECK, the compare as well.
  fpu_vector_rom u_rom (
    .idx_i (idx_d),
    .vec_o (vec)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    sample_d = sample_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    map_d    = map_q;
    busy_d   = busy_q;
    done_d   = done_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          idx_d   = '0;
          cnt_d   = 4'd1;
          pass_d  = '0;
          fail_d  = '0;
          map_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == LAT_C) begin
          sample_d = fpu.flags;
          state_d  = S_CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_CHECK: begin
        // Written pass-first so an unknown compare lands in the fail branch
        if (((sample_q ^ vec.exp) & vec.mask) == 8'h00) begin
          pass_d = pass_q + 5'd1;
        end else begin
          fail_d       = fail_q + 5'd1;
          map_d[idx_q] = 1'b1;
        end
        state_d = S_GAP;
        cnt_d   = 4'd1;
      end
      S_GAP: begin
        if (cnt_q == GAP_C) begin
          if (idx_q == 4'hF) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 4'd1;
            cnt_d   = 4'd1;
            state_d = S_DRIVE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DRIVE || state_d == S_CHECK) begin
      opa_d = vec.opa;
      opb_d = vec.opb;
      op_d  = vec.op;
    end else begin
      opa_d = ONE;
      opb_d = ONE;
      op_d  = OP_ADD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      sample_q <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      map_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      opa_q    <= ONE;
      opb_q    <= ONE;
      op_q     <= OP_ADD;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      map_q    <= map_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
    end
  end

  assign fpu.opa    = opa_q;
  assign fpu.opb    = opb_q;
  assign fpu.fpu_op = op_q;
  assign fpu.rmode  = 2'b00;

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign fail_map = map_q;

endmodule

// File: doc/fpu_vector_driver.md
Name: fpu_vector_driver

Overview:
- Synthesizable stimulus source that drives the single-precision FPU input side: opa, opb, fpu_op and rmode.
- On start, it steps through a fixed 16-entry corner-case table (zero, inf, NaN, overflow, underflow, inexact, div-by-zero).
- For each entry it samples the FPU flag outputs LATENCY cycles after presentation and compares them against a masked expected value.
- It keeps pass/fail counts and a per-vector fail bitmap. It is the drive-side counterpart to the flag property checker and sits beside the FPU in the top.

Parameters:
- LATENCY, 4, cycles from operands presented (first cycle driven) to the flag sample; legal range 1..15.
- GAP, 2, idle cycles driving the neutral vector between table entries; legal range 1..15.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a table run; honoured only in IDLE or DONE
- opa  out  32  operand A
- opb  out  32  operand B
- fpu_op  out  3  000 add, 001 sub, 010 mul, 011 div
- rmode  out  2  rounding mode; constant 2'b00 (nearest-even)
- flags  in  8  {inf,snan,qnan,ine,overflow,underflow,zero,div_by_zero} from FPU
- busy  out  1  high while a run is in progress
- done  out  1  high in DONE until next start or reset
- pass_cnt  out  5  vectors passed (0..16)
- fail_cnt  out  5  vectors failed (0..16)
- fail_map  out  16  bit i set when vector i failed

Behaviour:
- Reset/neutral values:
  - All outputs are registered.
  - Reset sets state IDLE, index 0, busy=0, done=0, counts=0, fail_map=0.
  - Neutral vector: opa=opb=32'h3F800000, fpu_op=000. It is driven in IDLE, GAP and DONE.
  - rmode=00 at all times, including reset.
- FSM states: IDLE, DRIVE, CHECK, GAP, DONE.
- IDLE/DONE + start=1:
  - Clear counts, fail_map and index.
  - Next state DRIVE, busy=1, done=0.
  - Vector 0 appears on opa/opb/fpu_op the cycle after start is sampled.
- DRIVE:
  - Hold table[index] operands.
  - The wait counter starts at 1 in the first driven cycle.
  - When counter==LATENCY, register flags into a sample and go to CHECK.
- CHECK (1 cycle):
  - Operands are still held.
  - pass if ((sample ^ exp) & mask)==0; update pass_cnt or fail_cnt and fail_map[index].
  - Go to GAP.
- GAP:
  - Drive the neutral vector for GAP cycles.
  - Then, if index==15, go to DONE (busy=0, done=1); else index+1 and go to DRIVE.
- Per-vector period is LATENCY+1+GAP cycles. With defaults, the full run takes 16*7=112 cycles from the first drive to done.
- Boundaries:
  - start while busy: ignored.
  - start in the same cycle as rst: rst wins.
  - rst mid-run: returns to IDLE next edge, with all counts and map cleared and the neutral vector driven.
  - index stops at 15 and never wraps.
  - Counters cannot exceed 16.
  - pass_cnt+fail_cnt==16 whenever done=1.
- Flags with X/Z compare as mismatch (treated as fail) in simulation.
- Table (op, opa, opb -> expected bits set; mask = listed bits, unless noted):
  - 0: add 3F800000, BF800000 -> zero
  - 1: sub 40490FDB, 40490FDB -> zero
  - 2: mul 00000000, 40400000 -> zero
  - 3: div 00000000, 40400000 -> zero
  - 4: div 3F800000, 00000000 -> div_by_zero
  - 5: add 7F800000, 3F800000 -> inf
  - 6: mul 7F800000, 40000000 -> inf
  - 7: mul 00000000, 7F800000 -> qnan
  - 8: sub 7F800000, 7F800000 -> qnan
  - 9: div 7F800000, 7F800000 -> qnan
  - 10: div 00000000, 00000000 -> qnan
  - 11: mul 7F7FFFFF, 40000000 -> overflow
  - 12: add 7F7FFFFF, 7F7FFFFF -> overflow
  - 13: div 00000001, 40000000 -> underflow
  - 14: mul 3F800000, 3F800000 -> none; mask 8'hFF, expected 00
  - 15: add 3F800000, 33800000 -> ine

Decomposition:
- Shared package fpu_tb_pkg holds:
  - op codes OP_ADD..OP_DIV;
  - constants INF=7F800000, ZERO=0, NUM_MAX=7F7FFFFF, NUM_MIN=00000001, ONE=3F800000;
  - flag bit indices F_INF..F_DBZ;
  - typedef fpu_vec_t {op, opa, opb, exp, mask}.
- One sub-module, fpu_vector_rom: combinational 4-bit index -> fpu_vec_t.
- The FSM, counters and compare stay in fpu_vector_driver.

Test Plan:
- Ideal FPU model returning expected flags at LATENCY=4; start pulse -> done after 112 cycles, pass_cnt=16, fail_cnt=0, fail_map=0.
- Model forces zero=0 on vector 1 -> fail_cnt=1, fail_map=16'h0002, pass_cnt=15.
- Model sets ine=1 on vector 14 -> fail_map=16'h4000; a spurious ine on vector 0 -> no fail (bit is masked).
- rst asserted at cycle 40 of a run -> next edge busy=0, counts 0, opa=3F800000; a new start completes a clean run of 112 cycles.
- start re-pulsed at cycles 10 and 50 of a run -> ignored, done exactly 112 cycles after the first drive; start in DONE restarts with counts cleared.
- LATENCY=7, GAP=1 build -> flags sampled exactly 7 cycles after each vector's first drive; done after 16*9=144 cycles.
